// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the iterative AES-128 inverse cipher.
package aes_pkg;

  localparam int STATE_W    = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / round-key / plaintext-out bundle for aes_inv_cipher_iter.
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [0:STATE_W-1]   in_data;
  logic [3:0]           rk_round;
  logic [0:STATE_W-1]   rk_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:STATE_W-1]   out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_round, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_round, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, purely combinational 8-bit lookup.
module aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry n is byte n counting from the left.
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign dout = INV_SBOX[{din, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched from an external store.
// Optional build macro AES_INV_ZEROIZE_EN clears the state after delivery and masks out_data when idle.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  aes_inv_cipher_iter_if.slave bus
);

  fsm_e               fsm_q, fsm_d;
  logic [3:0]         round_q, round_d;
  logic [0:STATE_W-1] state_q, state_d;

  logic [0:STATE_W-1] shifted;
  logic [0:STATE_W-1] subbed;
  logic [0:STATE_W-1] added;
  logic [0:STATE_W-1] mixed;

  logic               in_ready_o;
  logic               busy_o;
  logic               out_valid_o;
  logic [3:0]         rk_round_o;

  // Per byte: InvShiftRows as wiring (out[r,c] = in[r,(c-r) mod 4]), then InvSubBytes.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;

    assign shifted[8*gi +: 8] = state_q[8*SRC +: 8];

    aes_inv_sbox u_sbox (
      .din  (shifted[8*gi +: 8]),
      .dout (subbed[8*gi +: 8])
    );
  end

  assign added = subbed ^ bus.rk_data;

  // InvMixColumns, one column of four bytes per iteration.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    assign a0 = added[32*gi      +: 8];
    assign a1 = added[32*gi + 8  +: 8];
    assign a2 = added[32*gi + 16 +: 8];
    assign a3 = added[32*gi + 24 +: 8];

    assign mixed[32*gi      +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^
                                    gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
    assign mixed[32*gi + 8  +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^
                                    gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
    assign mixed[32*gi + 16 +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^
                                    gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
    assign mixed[32*gi + 24 +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^
                                    gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (bus.in_valid) fsm_d = ST_ROUND;
      ST_ROUND: if (round_q == 4'd1) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_data ^ bus.rk_data;
          round_d = 4'(NUM_ROUNDS - 1);
        end
      end
      ST_ROUND: begin
        state_d = mixed;
        round_d = round_q - 4'd1;
      end
      ST_FINAL: state_d = added;
`ifdef AES_INV_ZEROIZE_EN
      ST_DONE: if (bus.out_ready) state_d = '0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    out_valid_o = 1'b0;
    rk_round_o  = 4'd0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        rk_round_o = 4'(NUM_ROUNDS);
      end
      ST_ROUND: begin
        busy_o     = 1'b1;
        rk_round_o = round_q;
      end
      ST_FINAL: busy_o = 1'b1;
      ST_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.busy      = busy_o;
  assign bus.out_valid = out_valid_o;
  assign bus.rk_round  = rk_round_o;

`ifdef AES_INV_ZEROIZE_EN
  assign bus.out_data = out_valid_o ? state_q : '0;
`else
  assign bus.out_data = state_q;
`endif

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  ciphertext offered
- in_ready  out  1  block can accept ciphertext
- in_data  in  [0:127]  ciphertext
- rk_round  out  4  index of round key requested this cycle
- rk_data  in  [0:127]  round key for rk_round, valid same cycle (combinational external key store)
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  [0:127]  plaintext
- busy  out  1  decryption in progress

Function
REQ-003 Byte i SHALL occupy bits [8i+:8]; column c SHALL be bytes 4c..4c+3; row r SHALL be byte index mod 4.
REQ-004 InvShiftRows SHALL map out[r,c] = in[r,(c-r) mod 4]; rows 1/2/3 SHALL rotate right by 1/2/3.
REQ-005 The FSM SHALL have states IDLE, ROUND, FINAL, DONE.
REQ-006 In IDLE: in_ready=1, rk_round=10; on in_valid&in_ready the block SHALL load state = in_data ^ rk_data, load round=9, and go to ROUND.
REQ-007 In ROUND: each cycle, with rk_round=round, the block SHALL compute state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data) and decrement round; when round==1 it SHALL go to FINAL.
REQ-008 In FINAL: rk_round=0; the block SHALL compute state = InvSubBytes(InvShiftRows(state)) ^ rk_data and go to DONE.
REQ-009 In DONE: out_valid=1, out_data=state; the block SHALL hold until out_ready, then return to IDLE.
REQ-010 Latency SHALL be fixed: out_valid rises 11 cycles after the input handshake cycle.
REQ-011 in_ready SHALL be 0 in ROUND, FINAL and DONE; in_valid SHALL be ignored there, with no queuing.
REQ-012 busy SHALL be 1 in ROUND, FINAL and DONE.
REQ-013 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-014 InvMixColumns SHALL use the GF(2^8) polynomial 0x11B with coefficients {0e,0b,0d,09}.

Reset
REQ-015 On rst the block SHALL go to IDLE asynchronously, with state=0, round=0, out_valid=0, busy=0, in_ready=1 after release, rk_round=10.
REQ-016 Reset asserted mid-decryption SHALL abort the operation; no partial result SHALL ever appear on out_data with out_valid=1.

Configuration
REQ-017 With macro AES_INV_ZEROIZE_EN defined:
- the state register SHALL clear to 0 in the cycle after the out handshake;
- out_data SHALL be forced to 0 whenever out_valid=0.
REQ-018 Without AES_INV_ZEROIZE_EN, the state register SHALL retain the last plaintext and out_data SHALL always reflect state.

Structure
REQ-019 The shared package aes_pkg SHALL hold:
- the state width constant (128);
- the round count constant (10);
- the FSM state typedef;
- xtime/gf_mul functions.
REQ-020 One sub-module, aes_inv_sbox (8-bit in/out, combinational), SHALL be instantiated 16 times for InvSubBytes; InvShiftRows and InvMixColumns SHALL be in-module combinational logic.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- FIPS-197 C.1, key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after handshake.
- rk_round sequence after handshake -> 10 (handshake), 9,8,...,1, 0, observed cycle by cycle.
- out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0; release -> IDLE next cycle.
- in_valid=1 pulsed during ROUND with other data -> ignored; result unchanged from first vector.
- rst asserted at round 5 -> immediate IDLE, out_valid=0; next vector decrypts correctly.
- With AES_INV_ZEROIZE_EN: after out handshake -> state and out_data read 0; without it -> out_data keeps 00112233...eeff.
